store_buffer: RTL and testbench

Posted-store buffer sitting between the MEM-stage store path and the data memory, on the memory's only write port. Accepts lane-aligned stores (address, data, byte enables, PC) into a small FIFO and drains them one per cycle into the data memory. Drains only on cycles when no load owns the memory's shared address port. Loads get their read data from the memory merged per byte with any younger buffered store bytes.

---
 rtl/store_buffer.sv | 141 ++++++++++++++
 tb/tb_store_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO placed in front of the data memory's only write port.
// Stores are queued in order and drained one per cycle, but only on cycles when no load
// holds the memory's shared address port. Load data is merged per byte with any matching
// buffered store bytes, and the youngest matching store wins each lane.
// Optional feature: define SB_COALESCE_EN so that a store to the same word as the youngest
// entry is merged into that entry instead of taking a new one.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [13:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_byteen,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [13:0] ld_addr,
  input  logic [31:0] dm_RD,
  output logic [31:0] ld_data,
  output logic        ld_hit,
  output logic [13:0] dm_A,
  output logic [31:0] dm_WD,
  output logic [3:0]  dm_byteen,
  output logic [31:0] dm_PC,
  output logic        sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [11:0]   e_word   [DEPTH];
  logic [31:0]   e_data   [DEPTH];
  logic [3:0]    e_byteen [DEPTH];
  logic [31:0]   e_pc     [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] last;
  logic [CW-1:0] count;

  logic          drain;
  logic          push_req;
  logic          do_alloc;
  logic          do_merge;
  logic [3:0]    hit_lanes;

  // The two low address bits only select a byte inside the word, so the buffer never uses them.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  assign last     = tail - PW'(1);
  assign drain    = !ld_valid && (count != '0) && reset;
  assign push_req = st_valid && (st_byteen != 4'b0000);
  assign st_ready = (count < CW'(DEPTH));
  assign sb_empty = (count == '0);

  assign dm_A      = ld_valid ? ld_addr : {e_word[head], 2'b00};
  assign dm_WD     = e_data[head];
  assign dm_PC     = e_pc[head];
  assign dm_byteen = drain ? e_byteen[head] : 4'b0000;

`ifdef SB_COALESCE_EN
  logic can_merge;

  // Merge into the youngest entry when it holds the same word, unless that entry is also the head being popped now.
  always_comb begin
    can_merge = (count != '0) && (e_word[last] == st_addr[13:2]) && !(drain && (count == CW'(1)));
    do_merge  = push_req && can_merge;
    do_alloc  = push_req && st_ready && !can_merge;
  end
`else
  // Every accepted store takes its own entry.
  always_comb begin
    do_merge = 1'b0;
    do_alloc = push_req && st_ready;
  end
`endif

  // Per-lane forwarding: walk from oldest to youngest so a younger match overwrites an older one.
  always_comb begin
    logic [PW-1:0] idx;
    ld_data   = dm_RD;
    hit_lanes = 4'b0000;
    idx       = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (e_word[idx] == ld_addr[13:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (e_byteen[idx][b]) begin
            ld_data[8*b +: 8] = e_data[idx][8*b +: 8];
            hit_lanes[b]      = 1'b1;
          end
        end
      end
    end
    ld_hit = |hit_lanes;
  end

  // FIFO state: reset clears every entry, so the head fields read as zero until the next store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_word[i]   <= '0;
        e_data[i]   <= '0;
        e_byteen[i] <= '0;
        e_pc[i]     <= '0;
      end
    end else begin
      if (do_alloc) begin
        e_word[tail]   <= st_addr[13:2];
        e_data[tail]   <= st_data;
        e_byteen[tail] <= st_byteen;
        e_pc[tail]     <= st_pc;
        tail           <= tail + PW'(1);
      end
      if (do_merge) begin
        for (int b = 0; b < 4; b++) begin
          if (st_byteen[b]) begin
            e_data[last][8*b +: 8] <= st_data[8*b +: 8];
          end
        end
        e_byteen[last] <= e_byteen[last] | st_byteen;
        e_pc[last]     <= st_pc;
      end
      if (drain) begin
        head <= head + PW'(1);
      end
      case ({do_alloc, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven checks of store_buffer plus hand-written multi-cycle sequences.
// The expected coalescing behaviour follows SB_COALESCE_EN when the bench is built with it.
module tb_store_buffer;

`ifdef SB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [13:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_byteen;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [13:0] ld_addr;
  logic [31:0] dm_RD;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic [13:0] dm_A;
  logic [31:0] dm_WD;
  logic [3:0]  dm_byteen;
  logic [31:0] dm_PC;
  logic        sb_empty;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic        rst;
    logic        sv;
    logic [13:0] sa;
    logic [31:0] sd;
    logic [3:0]  sbe;
    logic        lv;
    logic [13:0] la;
    logic [31:0] rd;
    logic        exp_ready;
    logic        exp_empty;
    logic [3:0]  exp_be;
    logic [13:0] exp_a;
    logic [31:0] exp_wd;
    logic [31:0] exp_pc;
    logic [31:0] exp_ld;
    logic        exp_hit;
  } vec_t;

  typedef struct {
    logic [13:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    int          cyc;
  } drain_t;

  vec_t   vecs [11];
  drain_t drain_log [$];
  drain_t expected_log [$];
  drain_t mon_rec;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byteen(st_byteen),
    .st_pc(st_pc), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .dm_RD(dm_RD),
    .ld_data(ld_data), .ld_hit(ld_hit),
    .dm_A(dm_A), .dm_WD(dm_WD), .dm_byteen(dm_byteen), .dm_PC(dm_PC),
    .sb_empty(sb_empty)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Cycle counter used to check that drains land on consecutive cycles.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write the buffer issues, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && dm_byteen != 4'b0000) begin
      mon_rec.a   = dm_A;
      mon_rec.wd  = dm_WD;
      mon_rec.be  = dm_byteen;
      mon_rec.cyc = cyc;
      drain_log.push_back(mon_rec);
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic rst, input logic sv, input logic [13:0] sa,
                              input logic [31:0] sd, input logic [3:0] sbe, input logic lv,
                              input logic [13:0] la, input logic [31:0] rd, input logic rdy,
                              input logic emp, input logic [3:0] be, input logic [13:0] a,
                              input logic [31:0] wd, input logic [31:0] pc,
                              input logic [31:0] ld, input logic hit);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sa = sa; v.sd = sd; v.sbe = sbe;
    v.lv = lv; v.la = la; v.rd = rd;
    v.exp_ready = rdy; v.exp_empty = emp; v.exp_be = be; v.exp_a = a;
    v.exp_wd = wd; v.exp_pc = pc; v.exp_ld = ld; v.exp_hit = hit;
    return v;
  endfunction

  task automatic stepClock;
    @(posedge clk);
    #1;
  endtask

  task automatic waitSample;
    @(negedge clk);
  endtask

  task automatic setStore(input logic v, input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_byteen = be;
    st_pc     = 32'h0000_4000 | {18'b0, a};
  endtask

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    setStore(v.sv, v.sa, v.sd, v.sbe);
    ld_valid = v.lv;
    ld_addr  = v.la;
    dm_RD    = v.rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic waitEmpty(input string name);
    for (int n = 0; n < 20; n++) begin
      waitSample;
      if (sb_empty) break;
      stepClock;
    end
    checkOutput(name, sb_empty, 1'b1);
    stepClock;
  endtask

  task automatic compareLog(input string tag);
    checkOutput({tag, "_count"}, drain_log.size(), expected_log.size());
    for (int i = 0; i < drain_log.size() && i < expected_log.size(); i++) begin
      checkOutput($sformatf("%s%0d_addr", tag, i), drain_log[i].a, expected_log[i].a);
      checkOutput($sformatf("%s%0d_data", tag, i), drain_log[i].wd, expected_log[i].wd);
      checkOutput($sformatf("%s%0d_be", tag, i), drain_log[i].be, expected_log[i].be);
    end
  endtask

  task automatic expectDrain(input logic [13:0] a, input logic [31:0] wd, input logic [3:0] be);
    drain_t d;
    d.a = a; d.wd = wd; d.be = be; d.cyc = 0;
    expected_log.push_back(d);
  endtask

  logic [13:0] arb_a  [4];
  logic [3:0]  arb_be [4];

  initial begin
    // Single store, partial-lane forwarding and reset values, one row per cycle.
    vecs[0]  = mk(0, 0, 14'h0000, 32'h0, 4'h0, 1, 14'h0123, 32'hDEADBEEF, 1, 1, 4'h0, 14'h0123, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    vecs[1]  = mk(1, 1, 14'h0010, 32'h11223344, 4'hF, 0, 14'h0000, 32'h0, 1, 1, 4'h0, 14'h0000, 32'h0, 32'h0, 32'h0, 0);
    vecs[2]  = mk(1, 0, 14'h0000, 32'h0, 4'h0, 0, 14'h0200, 32'h55, 1, 0, 4'hF, 14'h0010, 32'h11223344, 32'h4010, 32'h55, 0);
    vecs[3]  = mk(1, 0, 14'h0000, 32'h0, 4'h0, 0, 14'h0010, 32'hAAAAAAAA, 1, 1, 4'h0, 14'h0000, 32'h0, 32'h0, 32'hAAAAAAAA, 0);
    vecs[4]  = mk(1, 1, 14'h0021, 32'h0000AA00, 4'b0010, 1, 14'h0300, 32'h0, 1, 1, 4'h0, 14'h0300, 32'h0, 32'h0, 32'h0, 0);
    vecs[5]  = mk(1, 1, 14'h0021, 32'h0000BB00, 4'b0010, 1, 14'h0020, 32'h12345678, 1, 0, 4'h0, 14'h0020, 32'h0000AA00, 32'h4021, 32'h1234AA78, 1);
    vecs[6]  = mk(1, 0, 14'h0000, 32'h0, 4'h0, 1, 14'h0020, 32'h12345678, 1, 0, 4'h0, 14'h0020,
                  COALESCE ? 32'h0000BB00 : 32'h0000AA00, 32'h4021, 32'h1234BB78, 1);
    vecs[7]  = mk(1, 0, 14'h0000, 32'h0, 4'h0, 1, 14'h0024, 32'hCAFEF00D, 1, 0, 4'h0, 14'h0024,
                  COALESCE ? 32'h0000BB00 : 32'h0000AA00, 32'h4021, 32'hCAFEF00D, 0);
    vecs[8]  = mk(1, 0, 14'h0000, 32'h0, 4'h0, 0, 14'h0020, 32'h12345678, 1, 0, 4'b0010, 14'h0020,
                  COALESCE ? 32'h0000BB00 : 32'h0000AA00, 32'h4021, 32'h1234BB78, 1);
    if (COALESCE)
      vecs[9] = mk(1, 0, 14'h0000, 32'h0, 4'h0, 0, 14'h0020, 32'h12345678, 1, 1, 4'h0, 14'h0000, 32'h0, 32'h0, 32'h12345678, 0);
    else
      vecs[9] = mk(1, 0, 14'h0000, 32'h0, 4'h0, 0, 14'h0020, 32'h12345678, 1, 0, 4'b0010, 14'h0020, 32'h0000BB00, 32'h4021, 32'h1234BB78, 1);
    vecs[10] = mk(1, 0, 14'h0000, 32'h0, 4'h0, 0, 14'h0020, 32'h12345678, 1, 1, 4'h0, 14'h0000, 32'h0, 32'h0, 32'h12345678, 0);

    reset = 1'b0;
    setStore(0, 14'h0, 32'h0, 4'h0);
    ld_valid = 1'b0;
    ld_addr  = 14'h0;
    dm_RD    = 32'h0;
    stepClock;
    stepClock;

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      waitSample;
      checkOutput($sformatf("v%0d_ready", i), st_ready, vecs[i].exp_ready);
      checkOutput($sformatf("v%0d_empty", i), sb_empty, vecs[i].exp_empty);
      checkOutput($sformatf("v%0d_dm_byteen", i), dm_byteen, vecs[i].exp_be);
      checkOutput($sformatf("v%0d_dm_A", i), dm_A, vecs[i].exp_a);
      checkOutput($sformatf("v%0d_dm_WD", i), dm_WD, vecs[i].exp_wd);
      checkOutput($sformatf("v%0d_dm_PC", i), dm_PC, vecs[i].exp_pc);
      checkOutput($sformatf("v%0d_ld_data", i), ld_data, vecs[i].exp_ld);
      checkOutput($sformatf("v%0d_ld_hit", i), ld_hit, vecs[i].exp_hit);
      stepClock;
    end

    // Fill and back-pressure: loads hold off draining while four stores fill the buffer.
    drain_log.delete();
    expected_log.delete();
    ld_valid = 1'b1;
    ld_addr  = 14'h0ABC;
    dm_RD    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      setStore(1, 14'h0100 + 14'(4 * i), 32'hA0000000 + 32'(i), 4'hF);
      waitSample;
      checkOutput($sformatf("fill%0d_ready", i), st_ready, 1'b1);
      stepClock;
    end
    setStore(1, 14'h0110, 32'hA0000004, 4'hF);
    waitSample;
    checkOutput("full_ready", st_ready, 1'b0);
    checkOutput("full_empty", sb_empty, 1'b0);
    checkOutput("full_ld_be", dm_byteen, 4'h0);
    stepClock;
    ld_valid = 1'b0;
    waitSample;
    checkOutput("full_pop_ready", st_ready, 1'b0);
    checkOutput("full_pop_be", dm_byteen, 4'hF);
    checkOutput("full_pop_addr", dm_A, 14'h0100);
    stepClock;
    waitSample;
    checkOutput("refill_ready", st_ready, 1'b1);
    stepClock;
    setStore(0, 14'h0, 32'h0, 4'h0);
    waitEmpty("fill_drained");
    for (int i = 0; i < 5; i++) expectDrain(14'h0100 + 14'(4 * i), 32'hA0000000 + 32'(i), 4'hF);
    compareLog("fill");
    for (int i = 1; i < drain_log.size() && i < 5; i++)
      checkOutput($sformatf("fill%0d_consecutive", i), drain_log[i].cyc - drain_log[0].cyc, i);

    // Load/drain arbitration: two entries, ld_valid pulsed 1-0-1-0.
    drain_log.delete();
    expected_log.delete();
    ld_valid = 1'b1;
    ld_addr  = 14'h0ABC;
    setStore(1, 14'h0200, 32'hB0B0B0B0, 4'hF);
    stepClock;
    setStore(1, 14'h0204, 32'hB1B1B1B1, 4'hF);
    stepClock;
    setStore(0, 14'h0, 32'h0, 4'h0);
    arb_a  = '{14'h0ABC, 14'h0200, 14'h0ABC, 14'h0204};
    arb_be = '{4'h0, 4'hF, 4'h0, 4'hF};
    for (int i = 0; i < 4; i++) begin
      ld_valid = (i % 2 == 0);
      waitSample;
      checkOutput($sformatf("arb%0d_dm_A", i), dm_A, arb_a[i]);
      checkOutput($sformatf("arb%0d_be", i), dm_byteen, arb_be[i]);
      stepClock;
    end
    ld_valid = 1'b0;
    waitSample;
    checkOutput("arb_empty", sb_empty, 1'b1);
    stepClock;
    expectDrain(14'h0200, 32'hB0B0B0B0, 4'hF);
    expectDrain(14'h0204, 32'hB1B1B1B1, 4'hF);
    compareLog("arb");

    // Reset mid-drain: three entries, one drains, then reset with a store presented.
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setStore(1, 14'h0300 + 14'(4 * i), 32'hC0000000 + 32'(i), 4'hF);
      stepClock;
    end
    setStore(0, 14'h0, 32'h0, 4'h0);
    ld_valid = 1'b0;
    waitSample;
    checkOutput("rst_pre_be", dm_byteen, 4'hF);
    stepClock;
    reset = 1'b0;
    setStore(1, 14'h030C, 32'hC0000003, 4'hF);
    waitSample;
    checkOutput("rst_low_be", dm_byteen, 4'h0);
    stepClock;
    reset = 1'b1;
    setStore(0, 14'h0, 32'h0, 4'h0);
    drain_log.delete();
    expected_log.delete();
    waitSample;
    checkOutput("rst_empty", sb_empty, 1'b1);
    checkOutput("rst_ready", st_ready, 1'b1);
    checkOutput("rst_dm_WD", dm_WD, 32'h0);
    for (int i = 0; i < 6; i++) stepClock;
    compareLog("rst");

    // Coalescing: a filler store keeps the halfword entry off the head while the second half arrives.
    drain_log.delete();
    expected_log.delete();
    ld_valid = 1'b1;
    setStore(1, 14'h0080, 32'h01010101, 4'hF);
    stepClock;
    setStore(1, 14'h0040, 32'h0000BEEF, 4'b0011);
    stepClock;
    ld_valid = 1'b0;
    setStore(1, 14'h0042, 32'hCAFE0000, 4'b1100);
    stepClock;
    setStore(0, 14'h0, 32'h0, 4'h0);
    waitEmpty("coal_drained");
    expectDrain(14'h0080, 32'h01010101, 4'hF);
    if (COALESCE) begin
      expectDrain(14'h0040, 32'hCAFEBEEF, 4'hF);
    end else begin
      expectDrain(14'h0040, 32'h0000BEEF, 4'b0011);
      expectDrain(14'h0040, 32'hCAFE0000, 4'b1100);
    end
    compareLog("coal");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
